// File: rtl/mem_req_pkg.sv
// Shared types and defaults for the memory request controller.
package mem_req_pkg;

  localparam int DEF_AW      = 8;
  localparam int DEF_DW      = 32;
  localparam int DEF_RO_BASE = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Default-width request entry. The controller builds a matching entry type
  // from its own AW/DW and hands it to the FIFO.
  typedef struct packed {
    logic              wr;
    logic [DEF_AW-1:0] addr;
    logic [DEF_DW-1:0] wdata;
  } req_t;

  // True when an address falls in the read-only upper region.
  function automatic logic addr_is_ro(input logic [31:0] addr, input logic [31:0] ro_base);
    return addr >= ro_base;
  endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// Show-ahead request FIFO: DEPTH entries of entry_t, full/empty flags,
// synchronous active-high reset flushes the pointers.
module mem_req_fifo
  import mem_req_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = req_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t din,
  input  logic   pop,
  output entry_t dout,
  output logic   full,
  output logic   empty
);

  localparam int PW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap freely.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == (PW+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/mem_req_ctrl.sv
// Request-side controller for the dummy memory: buffers valid/ready requests,
// issues single-cycle exclusive rd/wr strobes, blocks writes to the read-only
// upper region and returns one in-order response per request.
// Optional MEMREQ_STATS_EN adds saturating read/write/reject counters.
module mem_req_ctrl
  import mem_req_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int DEPTH   = 4,
  parameter int RO_BASE = DEF_RO_BASE,
  parameter int RD_LAT  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          mem_rd_en,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef MEMREQ_STATS_EN
  ,
  output logic [15:0]   stat_rd,
  output logic [15:0]   stat_wr,
  output logic [15:0]   stat_err
`endif
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_loc_t;

  req_loc_t fifo_din, fifo_head;
  logic     fifo_push, fifo_pop, fifo_full, fifo_empty;

  state_e        state_q, state_d;
  logic          ready_en_q, ready_en_d;
  logic          is_rd_q, is_rd_d;
  logic          rej_q, rej_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_rd_en_q, mem_rd_en_d;
  logic          mem_wr_en_q, mem_wr_en_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  // req_ready stays low through reset and rises on the first edge after release.
  assign req_ready = ready_en_q & ~fifo_full;
  assign fifo_push = req_valid & req_ready;
  assign fifo_din  = '{wr: req_wr, addr: req_addr, wdata: req_wdata};

  mem_req_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (req_loc_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state and registered-output logic of the issue/response FSM.
  always_comb begin
    state_d     = state_q;
    ready_en_d  = 1'b1;
    is_rd_d     = is_rd_q;
    rej_d       = rej_q;
    cnt_d       = cnt_q;
    mem_rd_en_d = 1'b0;
    mem_wr_en_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    fifo_pop    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          is_rd_d  = ~fifo_head.wr;
          state_d  = ISSUE;
          if (!fifo_head.wr) begin
            rej_d       = 1'b0;
            mem_rd_en_d = 1'b1;
            mem_addr_d  = fifo_head.addr;
            mem_wdata_d = fifo_head.wdata;
          end else if (!addr_is_ro(32'(fifo_head.addr), 32'(RO_BASE))) begin
            rej_d       = 1'b0;
            mem_wr_en_d = 1'b1;
            mem_addr_d  = fifo_head.addr;
            mem_wdata_d = fifo_head.wdata;
          end else begin
            // Rejected write: bus stays untouched so the memory sees nothing.
            rej_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (is_rd_q) begin
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = rej_q;
          rsp_rdata_d = '0;
          state_d     = RESP;
        end
      end
      WAIT: begin
        if (cnt_q == CW'(RD_LAT - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = mem_rdata;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and output registers; reset discards any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ready_en_q  <= 1'b0;
      is_rd_q     <= 1'b0;
      rej_q       <= 1'b0;
      cnt_q       <= '0;
      mem_rd_en_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_en_q  <= ready_en_d;
      is_rd_q     <= is_rd_d;
      rej_q       <= rej_d;
      cnt_q       <= cnt_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign mem_rd_en = mem_rd_en_q;
  assign mem_wr_en = mem_wr_en_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

`ifdef MEMREQ_STATS_EN
  logic        rsp_fire;
  logic [15:0] stat_rd_q, stat_rd_d;
  logic [15:0] stat_wr_q, stat_wr_d;
  logic [15:0] stat_err_q, stat_err_d;

  assign rsp_fire = rsp_valid_q & rsp_ready;

  // Classify each completed response and bump the matching saturating counter.
  always_comb begin
    stat_rd_d  = stat_rd_q;
    stat_wr_d  = stat_wr_q;
    stat_err_d = stat_err_q;
    if (rsp_fire) begin
      if (is_rd_q) begin
        if (stat_rd_q != 16'hFFFF) stat_rd_d = stat_rd_q + 16'd1;
      end else if (rej_q) begin
        if (stat_err_q != 16'hFFFF) stat_err_d = stat_err_q + 16'd1;
      end else begin
        if (stat_wr_q != 16'hFFFF) stat_wr_d = stat_wr_q + 16'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rd_q  <= '0;
      stat_wr_q  <= '0;
      stat_err_q <= '0;
    end else begin
      stat_rd_q  <= stat_rd_d;
      stat_wr_q  <= stat_wr_d;
      stat_err_q <= stat_err_d;
    end
  end

  assign stat_rd  = stat_rd_q;
  assign stat_wr  = stat_wr_q;
  assign stat_err = stat_err_q;
`endif

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl: directed latency/boundary cases,
// backpressure, reset mid-read and a randomized phase, all scored against an
// in-order response queue computed from a behavioural memory image.
module tb_mem_req_ctrl;

  localparam int AW      = 8;
  localparam int DW      = 32;
  localparam int DEPTH   = 4;
  localparam int RO_BASE = 128;
  localparam int RD_LAT  = 1;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_wr    = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          mem_rd_en;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
`ifdef MEMREQ_STATS_EN
  logic [15:0]   stat_rd, stat_wr, stat_err;
`endif

  always #5 clk = ~clk;

  mem_req_ctrl #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .RO_BASE(RO_BASE), .RD_LAT(RD_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_rd_en (mem_rd_en),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef MEMREQ_STATS_EN
    ,
    .stat_rd   (stat_rd),
    .stat_wr   (stat_wr),
    .stat_err  (stat_err)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Dummy memory: preloaded mem[i]=i, registered read on rd_en, write on negedge.
  logic [DW-1:0] tb_mem [1<<AW];
  bit            tb_mem_init = 1'b0;
  always @(posedge clk) if (mem_rd_en) mem_rdata <= tb_mem[mem_addr];
  always @(negedge clk) begin
    if (!tb_mem_init) begin
      for (int i = 0; i < (1<<AW); i++) tb_mem[i] = DW'(i);
      tb_mem_init = 1'b1;
    end
    if (mem_wr_en) tb_mem[mem_addr] = mem_wdata;
  end

  // Reference model: each accepted request immediately yields its response,
  // valid because requests execute strictly in order.
  typedef struct { logic [DW-1:0] rdata; logic err; } exp_t;
  exp_t          exp_q [$];
  exp_t          e_new;
  logic [DW-1:0] ref_mem [1<<AW];
  bit            ref_init = 1'b0;
  logic [AW-1:0] prev_addr  = '0;
  logic [DW-1:0] prev_wdata = '0;

  always @(negedge clk) begin
    if (!ref_init) begin
      for (int i = 0; i < (1<<AW); i++) ref_mem[i] = DW'(i);
      ref_init = 1'b1;
    end
    if (rst) begin
      exp_q.delete();
      prev_addr  = '0;
      prev_wdata = '0;
    end else begin
      if (mem_rd_en || mem_wr_en) begin
        check("strobe_excl", mem_rd_en & mem_wr_en, 0);
      end else begin
        check("addr_hold", mem_addr, prev_addr);
        check("wdata_hold", mem_wdata, prev_wdata);
      end
      if (mem_wr_en) check("wr_in_ro", (mem_addr >= RO_BASE), 0);
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", rsp_valid, 0);
        end else begin
          check("rsp_rdata", rsp_rdata, exp_q[0].rdata);
          check("rsp_err", rsp_err, exp_q[0].err);
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
      if (req_valid && req_ready) begin
        if (!req_wr) begin
          e_new = '{ref_mem[req_addr], 1'b0};
        end else if (req_addr < RO_BASE) begin
          ref_mem[req_addr] = req_wdata;
          e_new = '{'0, 1'b0};
        end else begin
          e_new = '{'0, 1'b1};
        end
        exp_q.push_back(e_new);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_checks();
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_mem_rd_en", mem_rd_en, 0);
    check("rst_mem_wr_en", mem_wr_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    tick();
    tick();
    zero_checks();
    rst = 1'b0;
    tick();
    check("rel_req_ready", req_ready, 1);
  endtask

  // One request from idle/empty; checks strobe timing, address and latency.
  task automatic single(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [DW-1:0] exp_rd, input logic exp_err);
    int lat;
    int exp_lat;
    bit exp_strobe;
    lat        = -1;
    exp_strobe = !(wr && (addr >= RO_BASE));
    exp_lat    = wr ? 2 : 2 + RD_LAT;
    check("single_ready", req_ready, 1);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wd;
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) begin
        check("strobe_rd_k1", mem_rd_en, !wr);
        check("strobe_wr_k1", mem_wr_en, wr && exp_strobe);
        if (exp_strobe) check("mem_addr_k1", mem_addr, addr);
        if (wr && exp_strobe) check("mem_wdata_k1", mem_wdata, wd);
      end
      if (k == 2) check("strobe_off_k2", mem_rd_en | mem_wr_en, 0);
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    check("rsp_latency", lat, exp_lat);
    check("rsp_data", rsp_rdata, exp_rd);
    check("rsp_err_flag", rsp_err, exp_err);
    tick();
  endtask

  logic          bp_wr    [6];
  logic [AW-1:0] bp_addr  [6];
  logic [DW-1:0] bp_wdata [6];

  initial begin
    int   idx;
    logic r;

    do_reset();
    $display("reset: req_ready=%0d", req_ready);

    single(1'b0, 8'h05, 32'h0, 32'h5, 1'b0);
    $display("read 0x05 -> 0x%0h", rsp_rdata);
    single(1'b1, 8'h7F, 32'hDEAD, 32'h0, 1'b0);
    $display("write 0x7F <- 0xDEAD");
    single(1'b0, 8'h7F, 32'h0, 32'hDEAD, 1'b0);
    $display("read 0x7F -> 0x%0h", rsp_rdata);
    single(1'b1, 8'h80, 32'h1234, 32'h0, 1'b1);
    $display("write 0x80 rejected, err=%0d", rsp_err);
    single(1'b0, 8'h80, 32'h0, 32'h80, 1'b0);
    $display("read 0x80 -> 0x%0h", rsp_rdata);

    // Reset while a read to 0x10 sits in WAIT.
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'h10; req_wdata = '0;
    tick();
    req_valid = 1'b0;
    tick();
    check("wrst_strobe", mem_rd_en, 1);
    tick();
    check("wrst_no_rsp", rsp_valid, 0);
    rst = 1'b1;
    tick();
    zero_checks();
    tick();
    rst = 1'b0;
    tick();
    check("wrst_ready", req_ready, 1);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("wrst_quiet_rsp", rsp_valid, 0);
      check("wrst_quiet_strobe", mem_rd_en | mem_wr_en, 0);
    end
    single(1'b0, 8'h11, 32'h0, 32'h11, 1'b0);
    $display("reset in WAIT, then read 0x11 -> 0x%0h", rsp_rdata);

    // Backpressure: six back-to-back requests with responses stalled.
    for (int i = 0; i < 6; i++) begin
      bp_wr[i]    = 1'($urandom_range(0, 1));
      bp_addr[i]  = AW'($urandom);
      bp_wdata[i] = $urandom;
    end
    rsp_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      if (idx < 6) begin
        req_valid = 1'b1; req_wr = bp_wr[idx]; req_addr = bp_addr[idx]; req_wdata = bp_wdata[idx];
      end else begin
        req_valid = 1'b0;
      end
      r = req_ready;
      tick();
      if (r && idx < 6) idx++;
    end
    check("bp_accepts", idx, 5);
    check("bp_ready_low", req_ready, 0);
    check("bp_rsp_held", rsp_valid, 1);
    rsp_ready = 1'b1;
    for (int c = 0; c < 200 && (idx < 6 || exp_q.size() != 0); c++) begin
      if (idx < 6) begin
        req_valid = 1'b1; req_wr = bp_wr[idx]; req_addr = bp_addr[idx]; req_wdata = bp_wdata[idx];
      end else begin
        req_valid = 1'b0;
      end
      r = req_ready;
      tick();
      if (r && idx < 6) idx++;
    end
    req_valid = 1'b0;
    check("bp_all_accepted", idx, 6);
    check("bp_drained", exp_q.size(), 0);
    $display("backpressure: accepted=%0d pending=%0d", idx, exp_q.size());

    // Randomized traffic with random response backpressure.
    for (int c = 0; c < 400; c++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_wr    = 1'($urandom_range(0, 1));
      req_addr  = ($urandom_range(0, 3) == 0) ? AW'(RO_BASE - 1 + $urandom_range(0, 2)) : AW'($urandom);
      req_wdata = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) tick();
    check("rand_drained", exp_q.size(), 0);
    $display("random phase: pending=%0d", exp_q.size());

`ifdef MEMREQ_STATS_EN
    do_reset();
    check("stat_rd_rst", stat_rd, 0);
    check("stat_wr_rst", stat_wr, 0);
    check("stat_err_rst", stat_err, 0);
    single(1'b0, 8'h01, 32'h0, ref_mem[1], 1'b0);
    single(1'b0, 8'h02, 32'h0, ref_mem[2], 1'b0);
    single(1'b1, 8'h20, 32'hA5A5, 32'h0, 1'b0);
    single(1'b0, 8'h20, 32'h0, 32'hA5A5, 1'b0);
    single(1'b1, 8'h30, 32'h5A5A, 32'h0, 1'b0);
    single(1'b1, 8'h90, 32'h7777, 32'h0, 1'b1);
    check("stat_rd", stat_rd, 3);
    check("stat_wr", stat_wr, 2);
    check("stat_err", stat_err, 1);
    $display("stats: rd=%0d wr=%0d err=%0d", stat_rd, stat_wr, stat_err);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000 expected earlier finish");
    $fatal(1, "timeout");
  end

endmodule
